// File: rtl/inst_mem_arbiter_pkg.sv
// inst_mem_arbiter_pkg
// Types and constants shared by the instruction-memory arbiter:
//   owner_e    - which port owns the read data returning next cycle
//   state_e    - arbitration state (FREE, or LOCKED for loader downloads)
//   WORD_SHIFT - byte-to-word address shift for 32-bit memory words
package inst_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/inst_mem_arbiter_age.sv
// inst_mem_arbiter_age
// Loader starvation guard. Counts cycles in which the loader is requesting
// but not granted, saturating at AGE_MAX. force_grant goes high once the
// count reaches AGE_MAX so the loader can win over fetch.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ld_req       - loader request
//   ld_gnt       - loader granted this cycle
//   force_grant  - loader has waited AGE_MAX cycles
module inst_mem_arbiter_age
  import inst_mem_arbiter_pkg::*;
#(
  parameter int AGE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_req,
  input  logic ld_gnt,
  output logic force_grant
);

  localparam int CNT_W = $clog2(AGE_MAX + 1);
  localparam logic [CNT_W-1:0] AGE_SAT = CNT_W'(AGE_MAX);

  logic [CNT_W-1:0] age_r;

  // Saturating wait counter; cleared when the loader is served or goes idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_r <= '0;
    end else if (!ld_req || ld_gnt) begin
      age_r <= '0;
    end else if (age_r != AGE_SAT) begin
      age_r <= age_r + 1'b1;
    end else begin
      age_r <= age_r;
    end
  end

  assign force_grant = (age_r == AGE_SAT);

endmodule

// File: rtl/inst_mem_arbiter.sv
// inst_mem_arbiter
// Shares a single-port, 1-cycle-latency instruction memory between the IF
// fetch port (read-only) and the program-loader/debug port (read/write).
// One command per cycle; read data is routed back to the issuing port.
// The loader can lock the memory (ld_lock) for an uninterrupted download.
// Optional feature macro: INST_MEM_ARBITER_AGING_EN (loader aging / forced
// grant after AGE_MAX waiting cycles). Default build: strict fetch priority.
// Ports:
//   clk, rst_n                          - clock, asynchronous active-low reset
//   if_req/if_addr/if_gnt               - fetch request, byte address, accept
//   if_rvalid/if_rdata                  - fetch read return
//   ld_req/ld_we/ld_lock/ld_addr/ld_wdata/ld_gnt - loader request and accept
//   ld_rvalid/ld_rdata                  - loader read return
//   mem_en/mem_we/mem_addr/mem_wdata    - memory command (word address)
//   mem_rdata                           - memory read data, 1 cycle after read
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int AGE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   run_r;
  state_e state_r;
  state_e state_nxt_s;
  owner_e owner_r;
  owner_e owner_nxt_s;
  logic   force_s;
  logic   unused_s;

  // Byte-offset bits are ignored; AGE_MAX only matters with aging enabled.
  assign unused_s = ^{if_addr[1:0], ld_addr[1:0], (AGE_MAX > 0)};

`ifdef INST_MEM_ARBITER_AGING_EN
  inst_mem_arbiter_age #(
    .AGE_MAX(AGE_MAX)
  ) u_age (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_req     (ld_req),
    .ld_gnt     (ld_gnt),
    .force_grant(force_s)
  );
`else
  assign force_s = 1'b0;
`endif

  // Grant arbitration. run_r holds grants low while reset is asserted so
  // every output reads 0 during reset. A LOCKED cycle with ld_lock=0 falls
  // through to FREE arbitration.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!run_r) begin
      if_gnt = 1'b0;
      ld_gnt = 1'b0;
    end else if ((state_r == LOCKED) && ld_lock) begin
      ld_gnt = ld_req;
    end else if (ld_req && (force_s || !if_req)) begin
      ld_gnt = 1'b1;
    end else begin
      if_gnt = if_req;
    end
  end

  // Memory command; address and write data are zero when idle.
  always_comb begin
    mem_en    = if_gnt | ld_gnt;
    mem_we    = ld_gnt & ld_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_addr  = ld_addr[ADDR_W-1:WORD_SHIFT];
      mem_wdata = ld_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr[ADDR_W-1:WORD_SHIFT];
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Next state and owner of the read returning next cycle.
  always_comb begin
    state_nxt_s = FREE;
    owner_nxt_s = OWN_NONE;
    if (ld_lock && (ld_gnt || (state_r == LOCKED))) begin
      state_nxt_s = LOCKED;
    end else begin
      state_nxt_s = FREE;
    end
    if (if_gnt) begin
      owner_nxt_s = OWN_IF;
    end else if (ld_gnt && !ld_we) begin
      owner_nxt_s = OWN_LD;
    end else begin
      owner_nxt_s = OWN_NONE;
    end
  end

  // State registers; reset drops any pending read return and any lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r   <= 1'b0;
      state_r <= FREE;
      owner_r <= OWN_NONE;
    end else begin
      run_r   <= 1'b1;
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
    end
  end

  // Read-return routing; the non-owner sees zero data.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ld_rvalid = 1'b0;
    ld_rdata  = '0;
    case (owner_r)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      OWN_LD: begin
        ld_rvalid = 1'b1;
        ld_rdata  = mem_rdata;
      end
      default: begin
        if_rvalid = 1'b0;
        ld_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_mem_arbiter.sv
module tb_inst_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ld_req;
  logic        ld_we;
  logic        ld_lock;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  logic [31:0] if_q[$];
  logic [31:0] ld_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  inst_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .AGE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro model: word i preloaded with {16'hC0DE, i}, 1-cycle read.
  initial begin
    mem_rdata = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = {16'hC0DE, 16'(i)};
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] = mem_wdata;
      else mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Monitor: pop the scoreboard whenever a read return is presented.
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        total_cnt++;
        $display("FAIL if_unexpected_rvalid: actual=1 required=0");
      end else begin
        chk("if_rdata", {32'h0, if_rdata}, {32'h0, if_q.pop_front()});
      end
      chk("ld_quiet_on_if_return", {31'h0, ld_rvalid, ld_rdata}, 64'h0);
    end
    if (ld_rvalid) begin
      if (ld_q.size() == 0) begin
        total_cnt++;
        $display("FAIL ld_unexpected_rvalid: actual=1 required=0");
      end else begin
        chk("ld_rdata", {32'h0, ld_rdata}, {32'h0, ld_q.pop_front()});
      end
      chk("if_quiet_on_ld_return", {31'h0, if_rvalid, if_rdata}, 64'h0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_if_gnt"}, 64'(if_gnt), 64'h0);
    chk({tag, "_ld_gnt"}, 64'(ld_gnt), 64'h0);
    chk({tag, "_mem_en_we"}, 64'({mem_en, mem_we}), 64'h0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'h0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'h0);
    chk({tag, "_rvalid"}, 64'({if_rvalid, ld_rvalid}), 64'h0);
    chk({tag, "_rdata"}, {if_rdata, ld_rdata}, 64'h0);
  endtask

  logic [31:0] t1_exp [3];
  logic [31:0] t3_data [4];

  initial begin
    t1_exp  = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002};
    t3_data = '{32'hDEADBEEF, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003};
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    next_cycle();

    // T1: consecutive fetch reads at 0x0, 0x4, 0x8
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(i * 4);
      @(negedge clk);
      chk("t1_if_gnt", 64'(if_gnt), 64'h1);
      chk("t1_mem_addr", 64'(mem_addr), 64'(i));
      chk("t1_mem_en_we", 64'({mem_en, mem_we}), 64'h2);
      if_q.push_back(t1_exp[i]);
      next_cycle();
    end
    if_req = 1'b0;
    next_cycle();

    // T2: simultaneous requests, fetch wins, loader reads 0x40 next
    if_req = 1'b1; if_addr = 32'hC;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
    @(negedge clk);
    chk("t2_fetch_wins", 64'({if_gnt, ld_gnt}), 64'h2);
    if_q.push_back(32'hC0DE0003);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    chk("t2_ld_gnt", 64'({if_gnt, ld_gnt}), 64'h1);
    chk("t2_mem_addr", 64'(mem_addr), 64'd16);
    ld_q.push_back(32'hC0DE0010);
    next_cycle();
    ld_req = 1'b0;
    next_cycle();

    // T3: locked loader writes block fetch; fetch resumes when lock drops
    for (int i = 0; i < 4; i++) begin
      if_req = (i != 0); if_addr = 32'h10;
      ld_req = 1'b1; ld_we = 1'b1; ld_lock = 1'b1;
      ld_addr = 32'h10 + 32'(i * 4); ld_wdata = t3_data[i];
      @(negedge clk);
      chk("t3_locked_grants", 64'({if_gnt, ld_gnt}), 64'h1);
      chk("t3_mem_we", 64'(mem_we), 64'h1);
      chk("t3_mem_addr", 64'(mem_addr), 64'(4 + i));
      chk("t3_mem_wdata", 64'(mem_wdata), 64'(t3_data[i]));
      next_cycle();
    end
    ld_lock = 1'b0; ld_addr = 32'h20; ld_wdata = 32'h12345678;
    @(negedge clk);
    chk("t3_unlock_fetch_wins", 64'({if_gnt, ld_gnt}), 64'h2);
    chk("t3_unlock_mem", {32'(mem_addr), 31'h0, mem_we}, {32'd4, 32'h0});
    if_q.push_back(32'hDEADBEEF);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    chk("t3_ld_write_after", 64'({ld_gnt, mem_we}), 64'h3);
    chk("t3_ld_write_addr", 64'(mem_addr), 64'd8);
    next_cycle();
    ld_req = 1'b0; ld_we = 1'b0;
    next_cycle();

    // T4: reset between fetch grant and its return
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    chk("t4_if_gnt", 64'(if_gnt), 64'h1);
    next_cycle();
    rst_n = 1'b0;
    ld_req = 1'b1; ld_we = 1'b1; ld_wdata = 32'h55AA55AA; ld_addr = 32'h4;
    @(negedge clk);
    check_all_zero("t4_in_reset");
    if_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0; ld_wdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_no_rvalid_after", 64'({if_rvalid, ld_rvalid}), 64'h0);
    next_cycle();

    // T5: loader aging against held fetch requests
    if_req = 1'b1; if_addr = 32'h0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h44;
`ifdef INST_MEM_ARBITER_AGING_EN
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("t5_wait_fetch_wins", 64'({if_gnt, ld_gnt}), 64'h2);
      if_q.push_back(32'hC0DE0000);
      next_cycle();
    end
    @(negedge clk);
    chk("t5_forced_ld_gnt", 64'({if_gnt, ld_gnt}), 64'h1);
    chk("t5_forced_addr", 64'(mem_addr), 64'd17);
    ld_q.push_back(32'hC0DE0011);
    next_cycle();
    @(negedge clk);
    chk("t5_age_cleared", 64'({if_gnt, ld_gnt}), 64'h2);
    if_q.push_back(32'hC0DE0000);
    next_cycle();
`else
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("t5_starve_fetch_wins", 64'({if_gnt, ld_gnt}), 64'h2);
      if_q.push_back(32'hC0DE0000);
      next_cycle();
    end
`endif
    if_req = 1'b0; ld_req = 1'b0;
    next_cycle();

    // T6: alternating fetch / loader / fetch reads back to back
    if_req = 1'b1; if_addr = 32'h4;
    @(negedge clk);
    chk("t6_c0", 64'({if_gnt, ld_gnt}), 64'h2);
    if_q.push_back(32'hC0DE0001);
    next_cycle();
    if_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h8;
    @(negedge clk);
    chk("t6_c1", 64'({if_gnt, ld_gnt}), 64'h1);
    ld_q.push_back(32'hC0DE0002);
    next_cycle();
    ld_req = 1'b0; if_req = 1'b1; if_addr = 32'hC;
    @(negedge clk);
    chk("t6_c2", 64'({if_gnt, ld_gnt}), 64'h2);
    if_q.push_back(32'hC0DE0003);
    next_cycle();
    if_req = 1'b0;
    repeat (3) next_cycle();

    chk("if_returns_all_seen", 64'(if_q.size()), 64'h0);
    chk("ld_returns_all_seen", 64'(ld_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
- Shares the single-port synchronous instruction memory between two requesters:
  - the IF stage fetch port (read-only);
  - the program-loader/debug port (read/write).
- Sits between the fetch stage, the loader and the memory macro; the memory has 1-cycle read latency.
- Issues at most one memory command per cycle and routes read data back to the issuing owner.
- Supports a loader lock for uninterrupted program download.

Parameters:
- ADDR_W, 32, byte-address width on both request ports.
- DATA_W, 32, instruction/data word width.
- AGE_MAX, 8, loader wait cycles before forced grant (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous active-low
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch command accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- ld_req  in  1  loader request
- ld_we  in  1  loader write (1) / read (0)
- ld_lock  in  1  loader requests exclusive ownership
- ld_addr  in  ADDR_W  loader byte address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader command accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read command

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous active-low.
- Reset values: all outputs 0; state FREE; owner register OWN_NONE; age counter 0.
- Grants and memory command are combinational from requests and current state. Requesters hold req/addr/data stable until they see gnt.
- Memory command:
  - mem_en = if_gnt | ld_gnt;
  - mem_we = ld_gnt & ld_we;
  - mem_addr = granted addr[ADDR_W-1:2]; addr[1:0] ignored;
  - mem_wdata = ld_wdata.
- Priority in FREE: fetch wins over loader when both request.
- States:
  - FREE: if the loader is granted with ld_lock=1, go to LOCKED.
  - LOCKED: only the loader can be granted; if_gnt=0 regardless of if_req. Go to FREE on the first cycle with ld_lock=0 (that cycle is arbitrated as FREE).
- Read return:
  - The owner of a granted read is registered (OWN_IF, OWN_LD, or OWN_NONE for writes/idle).
  - Next cycle, the matching rvalid is 1 and the matching rdata = mem_rdata. The non-owner's rdata is 0.
  - Read latency is exactly 1 cycle after gnt. Back-to-back reads from either port sustain 1 word/cycle.
- Writes: complete in the grant cycle; no rvalid is generated.
- Simultaneous grant-cycle events: a read returning to owner A and a new grant to B in the same cycle are independent. Both are legal.
- Reset mid-operation: a pending read return is discarded (no rvalid after reset deassertion); LOCKED is abandoned.
- ld_lock while ld_req=0: has no effect in FREE.

Optional Feature:
- Macro: INST_MEM_ARBITER_AGING_EN.
- Defined:
  - An age counter increments each cycle with ld_req=1 and ld_gnt=0, saturating at AGE_MAX.
  - At AGE_MAX the loader wins over fetch in FREE.
  - The counter clears on ld_gnt or when ld_req=0.
- Undefined: strict fetch priority; the loader may starve while if_req is held high; no counter logic is present.

Decomposition:
- Package inst_mem_arbiter_pkg holds:
  - owner enum OWN_NONE/OWN_IF/OWN_LD;
  - state enum FREE/LOCKED;
  - word-address shift constant 2.
- One sub-module, inst_mem_arbiter_age, contains the saturating wait counter and the force-grant flag. It is instantiated only under INST_MEM_ARBITER_AGING_EN.

Test Plan:
1. Reset then fetch reads at 0x0, 0x4, 0x8 on consecutive cycles -> if_gnt=1 each cycle; mem_addr 0,1,2; if_rvalid one cycle later with preloaded words; ld_rvalid=0 throughout.
2. Both request in the same cycle, loader reading 0x40 -> fetch granted, loader granted the first cycle if_req=0; ld_rdata = word 16 one cycle after ld_gnt.
3. Loader writes 0xDEADBEEF to 0x10 with ld_lock=1 for 4 writes while if_req=1 -> state LOCKED, if_gnt=0 for all 4 cycles, mem_we=1; fetch is granted the cycle ld_lock drops, and a read of 0x10 returns 0xDEADBEEF.
4. Fetch granted read, rst_n pulsed low before the return cycle -> no if_rvalid after reset; all outputs 0 during reset.
5. With INST_MEM_ARBITER_AGING_EN and AGE_MAX=8: if_req held high, ld_req high -> ld_gnt=1 on the 9th cycle; counter returns to 0; without the macro ld_gnt stays 0.
6. Back-to-back alternating grants (fetch read, loader read, fetch read) -> rvalid routed to the correct port each cycle with no cross-talk.
